// File: rtl/key_press_encoder_pkg.sv
// ---------------------------------------------------------------------------
// key_press_encoder_pkg
// Shared definitions for the digital lock front end and lock FSM:
//   - LOCK_NUM_KEYS     : number of board buttons feeding the lock
//   - enc_state_t       : key encoder FSM state encoding
//   - LOCK_LOCKED / LOCK_CORRECT_PASSWORD : lock FSM end-point encodings so
//     the encoder, lock FSM and top level all agree on the same values
// ---------------------------------------------------------------------------
package key_press_encoder_pkg;

    localparam int LOCK_NUM_KEYS = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        DEB_PRESS   = 2'b01,
        HELD        = 2'b10,
        DEB_RELEASE = 2'b11
    } enc_state_t;

    localparam logic [2:0] LOCK_LOCKED           = 3'b001;
    localparam logic [2:0] LOCK_CORRECT_PASSWORD = 3'b110;

endpackage

// File: rtl/key_synchroniser.sv
// ---------------------------------------------------------------------------
// key_synchroniser
// Two-flop synchroniser bringing asynchronous, active-low button levels into
// the clock domain. Resets to all-ones so every key reads "not pressed".
// Ports:
//   clock    : system clock
//   reset    : asynchronous active-low reset (0 = reset asserted)
//   i_async  : raw asynchronous input vector
//   o_sync   : synchronised copy of i_async, two clock edges later
// ---------------------------------------------------------------------------
module key_synchroniser #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/key_press_encoder.sv
// ---------------------------------------------------------------------------
// key_press_encoder
// Turns raw, bouncing, active-low buttons into clean single-cycle one-hot key
// events for the digital lock FSM. Rejects bounce, repeat while held and
// multi-key chords (a debounced chord raises multi_key for one cycle instead).
// Ports:
//   clock     : system clock (50 MHz)
//   reset     : asynchronous active-low reset (0 = reset asserted)
//   key_n     : raw buttons, 0 = pressed, asynchronous to clock
//   key       : one-hot pulse, high for exactly one cycle per accepted press
//   key_held  : high while an accepted press or chord is held
//   multi_key : one-cycle pulse when a debounced chord is rejected
// ---------------------------------------------------------------------------
module key_press_encoder
    import key_press_encoder_pkg::*;
#(
    parameter int NUM_KEYS        = LOCK_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key,
    output logic                key_held,
    output logic                multi_key
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]  w_sync;
    logic [NUM_KEYS-1:0]  w_pressed;
    logic                 w_candOneHot;

    enc_state_t           r_state;
    enc_state_t           w_stateNext;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cntNext;
    logic [NUM_KEYS-1:0]  r_cand;
    logic [NUM_KEYS-1:0]  w_candNext;
    logic [NUM_KEYS-1:0]  r_key;
    logic [NUM_KEYS-1:0]  w_keyNext;
    logic                 r_multi;
    logic                 w_multiNext;

    key_synchroniser #(
        .WIDTH   (NUM_KEYS)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (key_n),
        .o_sync  (w_sync)
    );

    assign w_pressed = ~w_sync;

    // x & (x-1) clears the lowest set bit, so a nonzero result means >1 key.
    assign w_candOneHot = (r_cand != '0) &&
                          ((r_cand & (r_cand - NUM_KEYS'(1))) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_key   <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_cand  <= w_candNext;
            r_key   <= w_keyNext;
            r_multi <= w_multiNext;
        end
    end

    // The counter is cleared on every entry to a debounce state, so it can
    // never run past CNT_LAST and wrap.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_candNext  = r_cand;
        w_keyNext   = '0;
        w_multiNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pressed != '0) begin
                    w_candNext  = w_pressed;
                    w_cntNext   = '0;
                    w_stateNext = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (w_pressed != r_cand) begin
                    w_stateNext = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = HELD;
                    if (w_candOneHot) begin
                        w_keyNext = r_cand;
                    end else begin
                        w_multiNext = 1'b1;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_WIDTH'(1);
                end
            end
            HELD: begin
                // Keys added while held are deliberately ignored.
                if (w_pressed == '0) begin
                    w_cntNext   = '0;
                    w_stateNext = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (w_pressed != '0) begin
                    w_stateNext = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign key       = r_key;
    assign multi_key = r_multi;
    assign key_held  = (r_state == HELD) || (r_state == DEB_RELEASE);

endmodule

// File: tb/tb_key_press_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_press_encoder
// Directed stimulus for key_press_encoder with DEBOUNCE_CYCLES = 4. Each
// stimulus step that should produce an event pushes the expected
// {multi_key, key} value and the cycle it must appear on into a queue; an
// independent monitor pops and compares whenever the DUT emits an event.
// ---------------------------------------------------------------------------
module tb_key_press_encoder;

    localparam int NUM_KEYS      = 4;
    localparam int DEBOUNCE      = 4;
    // 2 sync edges + 1 capture edge + 4 count edges, the first low sample
    // being one edge after the drive: event visible 7 cycles after driving.
    localparam int PULSE_LATENCY = 7;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } expect_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NUM_KEYS-1:0] keyN  = 4'b1111;
    logic [NUM_KEYS-1:0] key;
    logic                keyHeld;
    logic                multiKey;

    int      cycleCount = 0;
    int      checks     = 0;
    int      errors     = 0;
    expect_t expQ[$];

    key_press_encoder #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (keyN),
        .key       (key),
        .key_held  (keyHeld),
        .multi_key (multiKey)
    );

    // 100 MHz-style free-running clock; absolute rate does not matter here.
    always #5 clock = ~clock;

    // Cycle stamp: number of rising edges seen so far, read on falling edges.
    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Called on a falling edge: optionally queue the expected event, drive
    // the buttons, then hold them for the given number of cycles.
    task automatic applyStimulus(input logic [NUM_KEYS-1:0] keyVal, input int cycles,
                                 input bit expectEvent, input logic [4:0] expVal);
        expect_t e;
        if (expectEvent) begin
            e.cyc = cycleCount + PULSE_LATENCY;
            e.val = expVal;
            expQ.push_back(e);
        end
        keyN = keyVal;
        repeat (cycles) @(negedge clock);
    endtask

    // Monitor: any nonzero key or multi_key out of reset must match the
    // oldest queued expectation, both in value and in the cycle it shows up.
    always @(negedge clock) begin
        expect_t e;
        if (reset && ((key != '0) || multiKey)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedEvent", {multiKey, key}, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("eventValue", {multiKey, key}, e.val);
                checkOutput("eventCycle", cycleCount, e.cyc);
            end
        end
    end

    // Directed sequence: reset, clean press, bounce, chord, add-while-held,
    // and reset in the middle of a debounce.
    initial begin
        @(negedge clock);
        @(negedge clock);
        checkOutput("resetKey", key, 0);
        checkOutput("resetHeld", keyHeld, 0);
        checkOutput("resetMulti", multiKey, 0);
        reset = 1'b1;
        applyStimulus(4'b1111, 5, 1'b0, 5'b0);

        $display("[TB] clean press of key 0");
        applyStimulus(4'b1110, 10, 1'b1, 5'b00001);
        checkOutput("t1HeldWhilePressed", keyHeld, 1);
        applyStimulus(4'b1110, 10, 1'b0, 5'b0);
        applyStimulus(4'b1111, 6, 1'b0, 5'b0);
        checkOutput("t1HeldDuringRelease", keyHeld, 1);
        @(negedge clock);
        checkOutput("t1HeldAfterRelease", keyHeld, 0);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);

        $display("[TB] bouncing key 2");
        applyStimulus(4'b1011, 2, 1'b0, 5'b0);
        applyStimulus(4'b1111, 2, 1'b0, 5'b0);
        applyStimulus(4'b1011, 10, 1'b1, 5'b00100);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);

        $display("[TB] chord of keys 0 and 1");
        applyStimulus(4'b1100, 10, 1'b1, 5'b10000);
        checkOutput("t3HeldOnChord", keyHeld, 1);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);
        checkOutput("t3HeldAfterRelease", keyHeld, 0);

        $display("[TB] key 3 added while key 0 held");
        applyStimulus(4'b1110, 10, 1'b1, 5'b00001);
        applyStimulus(4'b0110, 10, 1'b0, 5'b0);
        checkOutput("t4HeldWithAddedKey", keyHeld, 1);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);
        applyStimulus(4'b0111, 10, 1'b1, 5'b01000);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);

        $display("[TB] reset during debounce of key 1");
        applyStimulus(4'b1101, 4, 1'b0, 5'b0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t5ResetKey", key, 0);
        checkOutput("t5ResetHeld", keyHeld, 0);
        checkOutput("t5ResetMulti", multiKey, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(4'b1101, 10, 1'b1, 5'b00010);
        applyStimulus(4'b1111, 10, 1'b0, 5'b0);

        checkOutput("pendingExpectations", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
